// File: rtl/ff_bank_universal.sv
// ff_bank_universal: WIDTH-bit register bank with a run-time selectable
// next-state function (D, T, JK, SR), clock enable, programmable reset value,
// and detection and saturating count of the SR forbidden input (S=R=1).
module ff_bank_universal #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0,
  parameter int unsigned            CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] err_mask,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_base;
  logic             illegal;

  assign mode_s = mode_e'(mode);

  // Next state of the storage bits and the illegal-input mask.
  always_comb begin
    q_d    = q_q;
    mask_d = '0;
    if (en) begin
      unique case (mode_s)
        MODE_D:  q_d = a;
        MODE_T:  q_d = q_q ^ a;
        // J sets a clear bit, ~K keeps a set bit: covers hold/clear/set/toggle.
        MODE_JK: q_d = (a & ~q_q) | (~b & q_q);
        // S-only sets, R-only clears; 00 and 11 both hold.
        MODE_SR: begin
          q_d    = (a & ~b) | (q_q & ~(~a & b));
          mask_d = a & b;
        end
        default: q_d = q_q;
      endcase
    end
  end

  // Next state of the sticky flag and saturating event counter.
  always_comb begin
    illegal  = en && (mode_s == MODE_SR) && (|(a & b));
    sticky_d = (sticky_q & ~clr_err) | illegal;
    cnt_base = clr_err ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (illegal && (cnt_base != '1)) begin
      cnt_d = cnt_base + CNT_W'(1);
    end
  end

  // State registers with synchronous, highest-priority reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q      <= RESET_VAL;
      mask_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      q_q      <= q_d;
      mask_q   <= mask_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q          = q_q;
  assign qbar       = ~q_q;
  assign err_mask   = mask_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;

endmodule
